// File: rtl/uart_rx_os_pkg.sv
// Shared constants and helpers for the oversampling UART receiver.
// FSM encodings, 3-input majority vote and baud divider derivation.
package uart_rx_os_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Byte hand-off bundle from the receiver to its consumer (valid/ready plus per-byte status).
// master = receiver side, slave = consumer side.
interface uart_rx_os_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_os_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clks, restartable by clr to re-phase on a start edge.
// First tick arrives DIV clks after clr; no backpressure.
module uart_baud_tick
  import uart_rx_os_pkg::*;
#(
  parameter int clk_freq   = 1843200,
  parameter int baud_rate  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = calc_div(clk_freq, baud_rate, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV < 1) begin : g_div_chk
      $error("uart_baud_tick: clock too slow for baud_rate*OVERSAMPLE");
    end
  endgenerate

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8-bit UART receiver with glitch-rejecting start detect, optional parity and stop check.
// Byte presented the clk after the stop-bit vote via a 1-entry valid/ready register; drops (overrun) when full.
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int clk_freq   = 1843200,
  parameter int baud_rate  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_rx_os_if.master  rxo
);

  generate
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
      $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
    end
  endgenerate

  localparam int   M   = OVERSAMPLE / 2;
  localparam int   SCW = $clog2(OVERSAMPLE);
  localparam logic POD = (PARITY_ODD != 0);
  localparam logic PEN = (PARITY_EN != 0);

  logic           rx_s1, rx_s2, rx_prev;
  logic [2:0]     state;
  logic [SCW-1:0] sc;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           par_acc, par_err_q;
  logic           smp0, smp1;
  logic           tick, fall, vote, at_vote, at_end, clr_div, load, accept;

  assign fall    = rx_prev & ~rx_s2;
  assign vote    = maj3(smp0, smp1, rx_s2);
  assign at_vote = tick && (sc == SCW'(M + 1));
  assign at_end  = tick && (sc == SCW'(OVERSAMPLE - 1));
  assign clr_div = (state == ST_IDLE) && fall;
  assign load    = (state == ST_STOP) && at_vote;
  assign accept  = rxo.rx_valid & rxo.rx_ready;
  assign rxo.busy = (state != ST_IDLE);

  uart_baud_tick #(
    .clk_freq   (clk_freq),
    .baud_rate  (baud_rate),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_div),
    .tick (tick)
  );

  // rx_prev is one stage past the synchroniser so fall sees a clean edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp0 <= 1'b1;
      smp1 <= 1'b1;
    end else if (tick) begin
      if (sc == SCW'(M - 1)) smp0 <= rx_s2;
      if (sc == SCW'(M))     smp1 <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      sc        <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      par_err_q <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (fall) begin
        state     <= ST_START;
        sc        <= '0;
        bit_idx   <= '0;
        par_acc   <= 1'b0;
        par_err_q <= 1'b0;
      end
    end else begin
      if (tick) sc <= (sc == SCW'(OVERSAMPLE - 1)) ? '0 : sc + SCW'(1);
      case (state)
        ST_START: begin
          // a start bit that has gone high again by mid-bit is treated as noise
          if (at_vote && vote) state <= ST_IDLE;
          else if (at_end)     state <= ST_DATA;
        end
        ST_DATA: begin
          if (at_vote) begin
            shreg   <= {vote, shreg[7:1]};
            par_acc <= par_acc ^ vote;
          end
          if (at_end) begin
            if (bit_idx == 3'd7) state <= PEN ? ST_PARITY : ST_STOP;
            bit_idx <= bit_idx + 3'd1;
          end
        end
        ST_PARITY: begin
          if (at_vote) par_err_q <= (vote != (par_acc ^ POD));
          if (at_end)  state <= ST_STOP;
        end
        ST_STOP: begin
          // leave at mid stop bit so the next start edge is never missed
          if (at_vote) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxo.rx_data    <= '0;
      rxo.rx_valid   <= 1'b0;
      rxo.frame_err  <= 1'b0;
      rxo.parity_err <= 1'b0;
      rxo.overrun    <= 1'b0;
    end else begin
      rxo.overrun <= 1'b0;
      if (load && (!rxo.rx_valid || accept)) begin
        rxo.rx_data    <= shreg;
        rxo.frame_err  <= ~vote;
        rxo.parity_err <= PEN & par_err_q;
        rxo.rx_valid   <= 1'b1;
      end else begin
        if (accept) rxo.rx_valid <= 1'b0;
        if (load)   rxo.overrun  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1 instance (dut0) and even-parity instance (dut1).
// Stimulus changes 1 time unit after the rising edge; monitors sample on the falling edge.
module tb_uart_rx_os;

  localparam int BT = 192;

  logic clk = 1'b0;
  logic rst;
  logic rx0, rx1;

  int checks = 0;
  int errors = 0;
  int hs0 = 0, hs1 = 0, ov0 = 0, vhi0 = 0;
  logic [7:0] cap0_d = '0, cap1_d = '0;
  logic cap0_fe = 1'b0, cap0_pe = 1'b0, cap1_fe = 1'b0, cap1_pe = 1'b0;
  logic hold = 1'b0;
  logic [7:0] hold_d = '0;
  int base;

  uart_rx_os_if u0_if ();
  uart_rx_os_if u1_if ();

  always #5 clk = ~clk;

  uart_rx_os #(.clk_freq(1843200), .baud_rate(9600), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0))
    dut0 (.clk(clk), .rst(rst), .rx(rx0), .rxo(u0_if.master));

  uart_rx_os #(.clk_freq(1843200), .baud_rate(9600), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0))
    dut1 (.clk(clk), .rst(rst), .rx(rx1), .rxo(u1_if.master));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int which, input logic v, input int n);
    if (which == 0) rx0 = v;
    else            rx1 = v;
    cycles(n);
  endtask

  // start, 8 data LSB first, optional parity, stop; no trailing idle
  task automatic send(input int which, input logic [7:0] d, input logic stop_b,
                      input logic par_on, input logic par_b, input int bt);
    drive(which, 1'b0, bt);
    for (int i = 0; i < 8; i++) drive(which, d[i], bt);
    if (par_on) drive(which, par_b, bt);
    drive(which, stop_b, bt);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (u0_if.rx_valid) vhi0++;
      if (u0_if.rx_valid && u0_if.rx_ready) begin
        hs0++;
        cap0_d  = u0_if.rx_data;
        cap0_fe = u0_if.frame_err;
        cap0_pe = u0_if.parity_err;
      end
      if (u0_if.overrun) ov0++;
      if (u1_if.rx_valid && u1_if.rx_ready) begin
        hs1++;
        cap1_d  = u1_if.rx_data;
        cap1_fe = u1_if.frame_err;
        cap1_pe = u1_if.parity_err;
      end
    end
  end

  // held byte must not move while the consumer stalls
  initial begin
    forever begin
      @(negedge clk);
      if (hold) begin
        checks++;
        assert (u0_if.rx_data === hold_d)
        else begin
          errors++;
          $error("FAIL hold_stable: observed %0h expected %0h", u0_if.rx_data, hold_d);
        end
      end
      hold   = rst && u0_if.rx_valid && !u0_if.rx_ready;
      hold_d = u0_if.rx_data;
    end
  end

  initial begin
    rst = 1'b0;
    rx0 = 1'b1;
    rx1 = 1'b1;
    u0_if.rx_ready = 1'b1;
    u1_if.rx_ready = 1'b1;
    cycles(4);
    chk("rst_data",   u0_if.rx_data, 8'h00);
    chk("rst_valid",  u0_if.rx_valid, 1'b0);
    chk("rst_fe",     u0_if.frame_err, 1'b0);
    chk("rst_pe",     u0_if.parity_err, 1'b0);
    chk("rst_ov",     u0_if.overrun, 1'b0);
    chk("rst_busy",   u0_if.busy, 1'b0);
    rst = 1'b1;
    cycles(20);

    // 8N1 frame, consumer always ready
    base = vhi0;
    send(0, 8'hA5, 1'b1, 1'b0, 1'b0, BT);
    drive(0, 1'b1, BT);
    chk("t1_hs",    hs0, 1);
    chk("t1_data",  cap0_d, 8'hA5);
    chk("t1_fe",    cap0_fe, 1'b0);
    chk("t1_pe",    cap0_pe, 1'b0);
    chk("t1_ov",    ov0, 0);
    chk("t1_vlen",  vhi0 - base, 1);
    chk("t1_valid", u0_if.rx_valid, 1'b0);

    // stop bit low, then line held low as a break
    send(0, 8'h3C, 1'b0, 1'b0, 1'b0, BT);
    drive(0, 1'b0, 3 * BT);
    chk("t2_break_busy", u0_if.busy, 1'b0);
    chk("t2_hs",    hs0, 2);
    chk("t2_data",  cap0_d, 8'h3C);
    chk("t2_fe",    cap0_fe, 1'b1);
    drive(0, 1'b1, BT);
    send(0, 8'h01, 1'b1, 1'b0, 1'b0, BT);
    drive(0, 1'b1, BT);
    chk("t2b_hs",   hs0, 3);
    chk("t2b_data", cap0_d, 8'h01);
    chk("t2b_fe",   cap0_fe, 1'b0);

    // 5-tick start glitch
    drive(0, 1'b0, 60);
    drive(0, 1'b1, 30);
    chk("t3_busy_mid", u0_if.busy, 1'b1);
    cycles(50);
    chk("t3_busy_end", u0_if.busy, 1'b0);
    cycles(BT);
    chk("t3_hs",       hs0, 3);

    // consumer stalled across two frames
    u0_if.rx_ready = 1'b0;
    send(0, 8'h11, 1'b1, 1'b0, 1'b0, BT);
    drive(0, 1'b1, BT);
    chk("t4_valid1", u0_if.rx_valid, 1'b1);
    chk("t4_data1",  u0_if.rx_data, 8'h11);
    send(0, 8'h22, 1'b1, 1'b0, 1'b0, BT);
    drive(0, 1'b1, BT);
    chk("t4_valid2", u0_if.rx_valid, 1'b1);
    chk("t4_data2",  u0_if.rx_data, 8'h11);
    chk("t4_ov",     ov0, 1);
    chk("t4_hs",     hs0, 3);
    u0_if.rx_ready = 1'b1;
    cycles(1);
    chk("t4_valid3", u0_if.rx_valid, 1'b0);
    chk("t4_hs2",    hs0, 4);
    chk("t4_cap",    cap0_d, 8'h11);

    // even parity on dut1: 0x07 has three ones, so the parity bit must be 1
    send(1, 8'h07, 1'b1, 1'b1, 1'b0, BT);
    drive(1, 1'b1, BT);
    chk("t5_hs",   hs1, 1);
    chk("t5_data", cap1_d, 8'h07);
    chk("t5_pe",   cap1_pe, 1'b1);
    chk("t5_fe",   cap1_fe, 1'b0);
    send(1, 8'h07, 1'b1, 1'b1, 1'b1, BT);
    drive(1, 1'b1, BT);
    chk("t5b_hs",  hs1, 2);
    chk("t5b_pe",  cap1_pe, 1'b0);
    send(1, 8'h03, 1'b1, 1'b1, 1'b0, BT);
    drive(1, 1'b1, BT);
    chk("t5c_data", cap1_d, 8'h03);
    chk("t5c_pe",   cap1_pe, 1'b0);

    // reset in the middle of data bit 3
    drive(0, 1'b0, BT);
    drive(0, 1'b1, BT);
    drive(0, 1'b0, BT);
    drive(0, 1'b1, BT);
    drive(0, 1'b0, BT / 2);
    chk("t6_busy_pre", u0_if.busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_data",  u0_if.rx_data, 8'h00);
    chk("t6_valid", u0_if.rx_valid, 1'b0);
    chk("t6_busy",  u0_if.busy, 1'b0);
    chk("t6_fe",    u0_if.frame_err, 1'b0);
    chk("t6_pe",    u0_if.parity_err, 1'b0);
    chk("t6_ov",    u0_if.overrun, 1'b0);
    rx0 = 1'b1;
    cycles(5);
    rst = 1'b1;
    cycles(2 * BT);
    chk("t6_nopart", hs0, 4);
    send(0, 8'h5A, 1'b1, 1'b0, 1'b0, BT);
    drive(0, 1'b1, BT);
    chk("t6_hs",    hs0, 5);
    chk("t6_rdata", cap0_d, 8'h5A);
    chk("t6_rfe",   cap0_fe, 1'b0);

    // +/-2% bit time
    send(0, 8'hFF, 1'b1, 1'b0, 1'b0, 196);
    drive(0, 1'b1, 196);
    chk("t7_slow_hs",   hs0, 6);
    chk("t7_slow_data", cap0_d, 8'hFF);
    chk("t7_slow_fe",   cap0_fe, 1'b0);
    send(0, 8'h00, 1'b1, 1'b0, 1'b0, 188);
    drive(0, 1'b1, 188);
    chk("t7_fast_hs",   hs0, 7);
    chk("t7_fast_data", cap0_d, 8'h00);
    chk("t7_fast_fe",   cap0_fe, 1'b0);
    chk("t7_ov",        ov0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
